vga_frame_reader: RTL and testbench

- Downstream consumer of the 640x480@60 Hz VGA timing generator. Converts timing (hsync, vsync, display_en, x, y) into framebuffer read addresses for the 320x240 RGB444 camera frame, with 2x pixel and line doubling.
- Realigns sync and blanking with synchronous-RAM read latency and drives the 4-bit-per-channel VGA DAC pins.
- Falls back to colour bars, switched only on frame boundaries, while the camera frame is not valid.

---
 rtl/vga_frame_reader_pkg.sv | 52 +++++
 rtl/vga_frame_reader_if.sv | 12 +
 rtl/vga_frame_reader_delay_pipe.sv | 34 +++
 rtl/vga_frame_reader.sv | 194 +++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared definitions for the VGA frame reader: display timing, RGB444 layout,
// colour-bar palette and display-mode encoding.
package vga_pkg;

   // 640x480@60 Hz horizontal timing, in pixel clocks
   localparam int H_VISIBLE     = 640;
   localparam int H_FRONT_PORCH = 16;
   localparam int H_SYNC_PULSE  = 96;
   localparam int H_BACK_PORCH  = 48;

   // 640x480@60 Hz vertical timing, in lines
   localparam int V_VISIBLE     = 480;
   localparam int V_FRONT_PORCH = 10;
   localparam int V_SYNC_PULSE  = 2;
   localparam int V_BACK_PORCH  = 33;

   // RGB444 field positions inside a framebuffer word
   localparam int RGB_R_HI = 11;
   localparam int RGB_R_LO = 8;
   localparam int RGB_G_HI = 7;
   localparam int RGB_G_LO = 4;
   localparam int RGB_B_HI = 3;
   localparam int RGB_B_LO = 0;

   // Colour-bar palette, selected by x[9:7]
   localparam logic [11:0] BAR_WHITE   = 12'hFFF;
   localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
   localparam logic [11:0] BAR_CYAN    = 12'h0FF;
   localparam logic [11:0] BAR_GREEN   = 12'h0F0;
   localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
   localparam logic [11:0] BAR_BLACK   = 12'h000;

   typedef enum logic {
      BARS   = 1'b0,
      CAMERA = 1'b1
   } mode_e;

   // Colour of the 128-pixel-wide bar that column group sel falls in
   function automatic logic [11:0] bar_colour(input logic [2:0] sel);
      logic [11:0] colour;
      case (sel)
         3'd0:    colour = BAR_WHITE;
         3'd1:    colour = BAR_YELLOW;
         3'd2:    colour = BAR_CYAN;
         3'd3:    colour = BAR_GREEN;
         3'd4:    colour = BAR_MAGENTA;
         default: colour = BAR_BLACK;
      endcase
      return colour;
   endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port: the reader issues an address, the RAM answers with
// a pixel word a fixed number of cycles later.
interface vga_frame_reader_if #(
   parameter int ADDR_W = 17,
   parameter int PIX_W  = 12
);
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;

   modport master (output rd_addr, input rd_data);
   modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_frame_reader_delay_pipe.sv
// Fixed-depth shift register used to hold timing and colour side-band data
// while the framebuffer read is in flight. Every stage loads rst_val on reset.
module vga_delay_pipe
   import vga_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift the side-band word one stage per clock
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= rst_val;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame reader: turns 640x480 timing into 2x-scaled framebuffer reads of a
// 320x240 RGB444 frame, realigns syncs with the RAM latency and falls back to
// colour bars (switching only at frame boundaries) when no frame is valid.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int SRC_W       = 320,
   parameter int SRC_H       = 240,
   parameter int ADDR_W      = 17,
   parameter int PIX_W       = 12,
   parameter int RAM_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               display_en_in,
   input  logic [9:0]         x_in,
   input  logic [9:0]         y_in,
   input  logic               fb_valid,
   vga_frame_reader_if.master fb,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start
);

   // Side-band word carried alongside the read: {mode, bar_rgb, de, vsync, hsync}
   localparam int PIPE_W = 16;
   localparam logic [PIPE_W-1:0] PIPE_RST = {1'b0, 12'h000, 1'b0, 1'b1, 1'b1};

   // Stage A state
   logic [ADDR_W-1:0] row_base_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic              de_prev_r;
   logic [9:0]        y_prev_r;
   logic              vsync_prev_r;
   logic              hsync_a_r;
   logic              vsync_a_r;
   logic              de_a_r;
   logic [11:0]       bar_a_r;

   // Mode FSM
   mode_e             mode_r;
   mode_e             mode_next_s;
   logic              mode_cam_s;

   logic              line_end_s;
   logic              vsync_fall_s;
   logic              pix_ok_s;

   // Pipe and output stage
   logic [PIPE_W-1:0] pipe_in_s;
   logic [PIPE_W-1:0] pipe_out_s;
   logic              mode_p_s;
   logic [11:0]       bar_p_s;
   logic              de_p_s;
   logic              vsync_p_s;
   logic              hsync_p_s;
   logic [PIX_W-1:0]  cam_rgb_s;
   logic [11:0]       rgb_s;

   assign line_end_s   = de_prev_r & ~display_en_in;
   assign vsync_fall_s = vsync_prev_r & ~vsync_in;
   assign pix_ok_s     = display_en_in & (x_in < 10'(H_VISIBLE));

   // Row base: cleared during vsync, advanced one source line after each odd
   // output line; the last line never advances so the base stays in range
   always_ff @(posedge clk) begin
      if (rst) begin
         row_base_r <= '0;
      end else if (!vsync_in) begin
         row_base_r <= '0;
      end else if (line_end_s && y_prev_r[0] && (y_prev_r < 10'(2 * SRC_H - 1))) begin
         row_base_r <= row_base_r + ADDR_W'(SRC_W);
      end else begin
         row_base_r <= row_base_r;
      end
   end

   // Stage A: issue the read address and register timing plus bar colour
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_r    <= '0;
         de_prev_r    <= 1'b0;
         y_prev_r     <= 10'd0;
         vsync_prev_r <= 1'b1;
         hsync_a_r    <= 1'b1;
         vsync_a_r    <= 1'b1;
         de_a_r       <= 1'b0;
         bar_a_r      <= 12'h000;
      end else begin
         rd_addr_r    <= pix_ok_s ? (row_base_r + ADDR_W'(x_in[9:1])) : '0;
         de_prev_r    <= display_en_in;
         y_prev_r     <= y_in;
         vsync_prev_r <= vsync_in;
         hsync_a_r    <= hsync_in;
         vsync_a_r    <= vsync_in;
         de_a_r       <= display_en_in;
         bar_a_r      <= bar_colour(x_in[9:7]);
      end
   end

   // Mode state register
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r <= BARS;
      end else begin
         mode_r <= mode_next_s;
      end
   end

   // Next mode: fb_valid is only looked at on the input vsync falling edge
   always_comb begin
      mode_next_s = mode_r;
      if (vsync_fall_s) begin
         if (fb_valid) begin
            mode_next_s = CAMERA;
         end else begin
            mode_next_s = BARS;
         end
      end else begin
         mode_next_s = mode_r;
      end
   end

   // Mode output decode; it is updated on the same edge as stage A so it
   // travels down the pipe together with the vsync that caused it
   always_comb begin
      mode_cam_s = 1'b0;
      if (mode_r == CAMERA) begin
         mode_cam_s = 1'b1;
      end else begin
         mode_cam_s = 1'b0;
      end
   end

   // Stage A plus this pipe make RAM_LATENCY+1 cycles, landing on rd_data
   assign pipe_in_s = {mode_cam_s, bar_a_r, de_a_r, vsync_a_r, hsync_a_r};

   vga_delay_pipe #(
      .WIDTH (PIPE_W),
      .DEPTH (RAM_LATENCY)
   ) u_delay_pipe (
      .clk     (clk),
      .rst     (rst),
      .rst_val (PIPE_RST),
      .din     (pipe_in_s),
      .dout    (pipe_out_s)
   );

   assign mode_p_s  = pipe_out_s[15];
   assign bar_p_s   = pipe_out_s[14:3];
   assign de_p_s    = pipe_out_s[2];
   assign vsync_p_s = pipe_out_s[1];
   assign hsync_p_s = pipe_out_s[0];
   assign cam_rgb_s = fb.rd_data;
   assign fb.rd_addr = rd_addr_r;

   // Pixel colour select: black in blanking, camera word or bar otherwise
   always_comb begin
      rgb_s = 12'h000;
      if (!de_p_s) begin
         rgb_s = 12'h000;
      end else if (mode_p_s) begin
         rgb_s = {cam_rgb_s[RGB_R_HI:RGB_R_LO], cam_rgb_s[RGB_G_HI:RGB_G_LO],
                  cam_rgb_s[RGB_B_HI:RGB_B_LO]};
      end else begin
         rgb_s = bar_p_s;
      end
   end

   // Output stage: DAC pins, realigned syncs and the frame-start pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r       <= 4'h0;
         vga_g       <= 4'h0;
         vga_b       <= 4'h0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= rgb_s[11:8];
         vga_g       <= rgb_s[7:4];
         vga_b       <= rgb_s[3:0];
         hsync       <= hsync_p_s;
         vsync       <= vsync_p_s;
         frame_start <= vsync & ~vsync_p_s;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: a compressed timing generator (short
// lines, full 480-line frames), a two-cycle RAM returning rd_addr[11:0] or a
// forced 12'hFFF, and per-step expected values for address, syncs and colour.
module tb_vga_frame_reader;
   import vga_pkg::*;

   localparam int SRC_W       = 320;
   localparam int SRC_H       = 240;
   localparam int ADDR_W      = 17;
   localparam int PIX_W       = 12;
   localparam int RAM_LATENCY = 2;
   // Steps launch inputs one edge before capture, so a lag of RAM_LATENCY+1
   // steps here is RAM_LATENCY+2 clock edges after the input changed.
   localparam int OUT_LAG = RAM_LATENCY + 1;
   localparam int HN      = 16;

   localparam int PH_RST = 0, PH_VB = 1, PH_A = 2, PH_B = 3, PH_C = 4, PH_D = 5, PH_E = 6;

   logic       clk = 1'b0;
   logic       rst, hsync_in, vsync_in, display_en_in, fb_valid;
   logic [9:0] x_in, y_in;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       hsync, vsync, frame_start;

   always #20 clk = ~clk;

   vga_frame_reader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) fb ();

   vga_frame_reader #(
      .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RAM_LATENCY(RAM_LATENCY)
   ) dut (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .display_en_in(display_en_in), .x_in(x_in), .y_in(y_in), .fb_valid(fb_valid),
      .fb(fb), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
   );

   // Two-cycle synchronous RAM model
   logic             ram_force;
   logic [PIX_W-1:0] ram_q1;
   always @(posedge clk) begin
      ram_q1     <= ram_force ? 12'hFFF : fb.rd_addr[11:0];
      fb.rd_data <= ram_q1;
   end

   int   n_assert = 0;
   int   n_fail   = 0;
   int   step_no  = 0;
   int   rst_left = 0;
   int   phase    = PH_RST;
   int   fs_cnt   = 0;
   int   hs_fall_step = -100;
   logic last_hs  = 1'b1;
   logic m_mode   = 1'b0;
   logic m_prev_vs = 1'b1;
   logic addr_ok  = 1'b0;
   logic exp_vs_prev = 1'b1;

   logic        h_rst [HN];
   logic        h_hs  [HN];
   logic        h_vs  [HN];
   logic        h_de  [HN];
   int          h_x   [HN];
   int          h_y   [HN];
   int          h_phase [HN];
   int          h_addr  [HN];
   logic        h_addr_ok [HN];
   logic [11:0] h_rgb [HN];

   function automatic logic [11:0] bar_of(input int x);
      case (x / 128)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         default: return 12'h000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
      end
   endtask

   // One clock of generator output, followed by all checks for that edge
   task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
      logic        r, inact, e_hs, e_vs, e_fs;
      logic [11:0] e_rgb, data, got_rgb;
      int          k, kk, j;
      r = (rst_left > 0);
      if (r) rst_left--;
      rst = r; hsync_in = hs; vsync_in = vs; display_en_in = de;
      x_in = 10'(x); y_in = 10'(y);

      if (r) begin
         m_mode = 1'b0; m_prev_vs = 1'b1; addr_ok = 1'b0;
      end else begin
         if (m_prev_vs && !vs) m_mode = fb_valid;
         m_prev_vs = vs;
         if (!vs) addr_ok = 1'b1;
      end
      if (phase == PH_A && y == 5 && last_hs && !hs) hs_fall_step = step_no;
      last_hs = hs;

      k = step_no % HN;
      h_rst[k] = r; h_hs[k] = hs; h_vs[k] = vs; h_de[k] = de;
      h_x[k] = x; h_y[k] = y; h_phase[k] = phase;
      h_addr[k] = (r || !de) ? 0 : (y / 2) * SRC_W + x / 2;
      h_addr_ok[k] = r || !de || addr_ok;
      data = ram_force ? 12'hFFF : 12'(h_addr[k]);
      h_rgb[k] = !de ? 12'h000 : (m_mode ? data : bar_of(x));

      @(posedge clk);
      #1;
      j = step_no;

      if (h_addr_ok[k]) chk("rd_addr", 32'(fb.rd_addr), 32'(h_addr[k]));
      if (!r && (phase == PH_A || phase == PH_E)) begin
         if (de && y == 0 && x == 0)     chk("addr_0_0", 32'(fb.rd_addr), 32'd0);
         if (de && y == 0 && x == 3)     chk("addr_3_0", 32'(fb.rd_addr), 32'd1);
         if (de && y == 1 && x == 639)   chk("addr_639_1", 32'(fb.rd_addr), 32'd319);
         if (de && y == 2 && x == 0)     chk("addr_0_2", 32'(fb.rd_addr), 32'd320);
         if (de && y == 479 && x == 639) chk("addr_639_479", 32'(fb.rd_addr), 32'd76799);
         if (!de && y == 7)              chk("addr_hblank", 32'(fb.rd_addr), 32'd0);
      end

      inact = 1'b0;
      for (int d = 0; d <= OUT_LAG; d++) begin
         if (j - d < 0) inact = 1'b1;
         else if (h_rst[(j - d) % HN]) inact = 1'b1;
      end
      kk = (j >= OUT_LAG) ? (j - OUT_LAG) % HN : 0;
      if (inact) begin
         e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
      end else begin
         e_hs = h_hs[kk]; e_vs = h_vs[kk]; e_rgb = h_rgb[kk];
      end
      e_fs = !r && exp_vs_prev && !e_vs;
      exp_vs_prev = e_vs;
      got_rgb = {vga_r, vga_g, vga_b};

      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("rgb", 32'(got_rgb), 32'(e_rgb));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      if (frame_start === 1'b1) fs_cnt++;

      if (j == hs_fall_step + 2) chk("hsync_lat_before", 32'(hsync), 32'd1);
      if (j == hs_fall_step + 3) chk("hsync_lat_at", 32'(hsync), 32'd0);

      if (!inact && h_de[kk]) begin
         if (h_phase[kk] == PH_A && h_y[kk] == 2 && h_x[kk] == 3)
            chk("cam_latency", 32'(got_rgb), 32'h141);
         if (h_phase[kk] == PH_B && h_y[kk] == 200 && h_x[kk] == 128)
            chk("cam_after_drop", 32'(got_rgb), 32'hFFF);
         if (h_phase[kk] == PH_C && h_y[kk] == 10 && h_x[kk] == 0)
            chk("bar_x0", 32'(got_rgb), 32'hFFF);
         if (h_phase[kk] == PH_C && h_y[kk] == 10 && h_x[kk] == 128)
            chk("bar_x128", 32'(got_rgb), 32'hFF0);
         if (h_phase[kk] == PH_C && h_y[kk] == 10 && h_x[kk] == 512)
            chk("bar_x512", 32'(got_rgb), 32'hF0F);
         if (h_phase[kk] == PH_C && h_y[kk] == 300 && h_x[kk] == 256)
            chk("bar_after_raise", 32'(got_rgb), 32'h0FF);
         if (h_phase[kk] == PH_D && h_y[kk] == 250 && h_x[kk] == 256)
            chk("bar_after_reset", 32'(got_rgb), 32'h0FF);
      end
      if (!inact && !h_de[kk] && h_phase[kk] == PH_B && h_y[kk] == 50)
         chk("blank_forced_ram", 32'(got_rgb), 32'h000);

      step_no++;
   endtask

   // One visible line: seven sample columns, then a short horizontal blank
   task automatic line(input int y);
      int xs [7];
      xs = '{0, 3, 128, 256, 384, 512, 639};
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, xs[i], y);
      for (int i = 0; i < 6; i++) step((i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, 0, y);
   endtask

   task automatic vblank();
      fs_cnt = 0;
      for (int ln = 0; ln < 6; ln++) begin
         for (int i = 0; i < 13; i++) begin
            step((i >= 9 && i <= 10) ? 1'b0 : 1'b1, (ln == 2 || ln == 3) ? 1'b0 : 1'b1,
                 1'b0, 0, 0);
         end
      end
      chk("frame_start_count", 32'(fs_cnt), 32'd1);
   endtask

   task automatic frame(input int nlines, input int fb_line, input logic fb_new, input int rst_line);
      for (int y = 0; y < nlines; y++) begin
         if (y == fb_line) fb_valid = fb_new;
         if (y == rst_line) rst_left = 5;
         line(y);
      end
   endtask

   initial begin
      rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; display_en_in = 1'b0;
      x_in = 10'd0; y_in = 10'd0; fb_valid = 1'b1; ram_force = 1'b0;

      phase = PH_RST; rst_left = 5; line(300);
      phase = PH_VB;  vblank();
      phase = PH_A;   frame(480, -1, 1'b1, -1);
      phase = PH_VB;  vblank();
      ram_force = 1'b1;
      phase = PH_B;   frame(480, 100, 1'b0, -1);
      phase = PH_VB;  vblank();
      ram_force = 1'b0;
      phase = PH_C;   frame(480, 100, 1'b1, -1);
      phase = PH_VB;  vblank();
      phase = PH_D;   frame(480, -1, 1'b1, 200);
      phase = PH_VB;  vblank();
      phase = PH_E;   frame(3, -1, 1'b1, -1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
